mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port arbiter between the instruction cache and the data cache, feeding the single shared 128-bit block memory port.
- Each cache-side port uses the same protocol the caches already use: a level request (read/write) held until a one-cycle ready pulse, with a block address and block data.
- The arbiter registers the winning request onto the memory bus, holds it until mem_ready, and routes the ready pulse and read data back to the winner only.

Parameters:
- ADDR_W, 28, block address width (word address minus 2 offset bits).
- DATA_W, 128, block data width.
- RR_EN, 1, 1 = round-robin between ports on simultaneous requests; 0 = fixed D-port priority.

Ports:
- clk  in  1  clock, all flops rising-edge
- proc_reset_n  in  1  asynchronous active-low reset
- i_read  in  1  I-cache block read request (level)
- i_write  in  1  I-cache block write request (level; normally 0)
- i_addr  in  ADDR_W  I-cache block address
- i_wdata  in  DATA_W  I-cache write block
- i_rdata  out  DATA_W  read block to I-cache
- i_ready  out  1  one-cycle completion pulse to I-cache
- d_read, d_write, d_addr, d_wdata, d_rdata, d_ready: same as the i_* ports, for the D-cache
- mem_read  out  1  registered memory read request
- mem_write  out  1  registered memory write request
- mem_addr  out  ADDR_W  registered memory block address
- mem_wdata  out  DATA_W  registered memory write block
- mem_rdata  in  DATA_W  memory read block
- mem_ready  in  1  memory completion pulse

Behaviour:
- States: IDLE, BUSY, GAP.
- Reset (async, proc_reset_n=0): state=IDLE; mem_read=0, mem_write=0; mem_addr=0, mem_wdata=0; grant=D; last_grant=I, so D wins the first tie. i_ready=d_ready=0 while in reset.
- IDLE:
  - A port is requesting if read|write is set.
  - If neither port requests, stay in IDLE.
  - If exactly one port requests, grant it.
  - If both request: with RR_EN=1, grant the port not equal to last_grant; with RR_EN=0, grant D.
  - On the grant edge: register mem_addr and mem_wdata from the winner; mem_write = winner.write; mem_read = winner.read & ~winner.write (write wins if both are set); update last_grant; go to BUSY.
  - Latency: request seen in cycle n, mem_read/mem_write high from cycle n+1.
- BUSY:
  - mem_* outputs are held stable; changes on the cache inputs are ignored.
  - When mem_ready=1: the granted port's ready is 1 in the same cycle (combinational), and its rdata is mem_rdata.
  - On that edge: mem_read and mem_write are cleared, and the state goes to GAP.
  - mem_ready pulses seen in IDLE or GAP are ignored; no ready is issued.
- GAP: exactly one cycle with mem_read=mem_write=0 and no ready, then IDLE. This guarantees the memory sees the request drop, and that the caches' registered request has been re-evaluated before arbitration.
- rdata: i_rdata and d_rdata are always driven with mem_rdata; they are valid only when the matching ready pulse is high.
- The non-granted port's ready stays 0 throughout.
- A loser keeps its request asserted and is served in the next IDLE.
- Back-to-back requests from the D-cache (write-back immediately followed by allocate read) appear as a new request after GAP. Arbitration then applies again, so with RR_EN=1 a pending I request is served between them.
- A request that drops in IDLE before being granted is simply not served.
- Reset mid-BUSY: the transaction is abandoned, outputs clear immediately, and no ready is issued.
- Worst-case starvation with RR_EN=1: one transaction.

Decomposition:
- Package mem_arb_pkg:
  - state encoding: IDLE=2'd0, BUSY=2'd1, GAP=2'd2
  - port IDs: PORT_I=1'b0, PORT_D=1'b1
  - default widths ADDR_W and DATA_W
- Sub-module rr_arb2: a 2-requester arbiter holding the last_grant flop. It takes req[1:0], an update enable and RR_EN, and produces a one-hot grant plus a grant index.
- The top level holds the FSM, the registered memory-side mux, and the ready/rdata routing.

Test Plan:
- Reset, then d_read=1, d_addr=28'h0000123 in cycle 0 → mem_read=1 and mem_addr=28'h0000123 from cycle 1. mem_ready at cycle 4 with mem_rdata=128'hA5..A5 → d_ready=1 and d_rdata=A5..A5 at cycle 4; mem_read=0 at cycle 5; i_ready=0 throughout.
- d_write=1, d_addr=28'h10, d_wdata=128'h1234 → mem_write=1, mem_wdata=128'h1234, mem_read=0. d_write held until the ready cycle, then d_read raised immediately for the allocate → after one GAP cycle, mem_read=1 with the new address.
- i_read and d_read both asserted from reset with RR_EN=1 → grants follow D, I, D, I. With RR_EN=0 → D is always granted while d_read is held, and i_ready never fires.
- Inputs change during BUSY (d_addr toggles, i_read rises) → mem_addr is unchanged and a single ready pulse goes to the original grantee.
- proc_reset_n driven low in the middle of BUSY → mem_read, mem_write and both ready outputs go to 0 asynchronously; after release the state is IDLE and the first tie is granted to D.
- mem_ready pulsed while in IDLE or GAP → no ready output and no state change.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D-cache to block-memory arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 28;
    localparam int DEF_DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester arbiter; req[0] is the I port, req[1] the D port.
module rr_arb2
    import mem_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    logic last_grant;

    // D is the default pick; on a tie round-robin flips away from the last winner.
    always_comb begin
        gnt_idx = PORT_D;
        if (req == 2'b11) begin
            gnt_idx = RR_EN ? ~last_grant : PORT_D;
        end else if (req[PORT_I]) begin
            gnt_idx = PORT_I;
        end
        gnt = (req == 2'b00) ? 2'b00 : {gnt_idx, ~gnt_idx};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT_I;
        end else if (update) begin
            last_grant <= gnt_idx;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the I-cache and D-cache block ports onto one registered memory port.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        dbg_state
);

    // Handshake: each cache holds read/write as a level until its ready pulses
    // for one cycle; the memory side holds mem_read/mem_write until mem_ready.

    state_t            state;
    logic              grant;
    logic [1:0]        req;
    logic [1:0]        gnt_oh;
    logic              gnt_idx;
    logic              arb_update;
    logic              win_read;
    logic              win_write;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              done;

    assign req        = {d_read | d_write, i_read | i_write};
    assign arb_update = (state == IDLE) && (req != 2'b00);

    rr_arb2 #(.RR_EN(RR_EN)) u_arb (
        .clk     (clk),
        .rst_n   (proc_reset_n),
        .req     (req),
        .update  (arb_update),
        .gnt     (gnt_oh),
        .gnt_idx (gnt_idx)
    );

    assign win_read  = gnt_oh[PORT_D] ? d_read  : i_read;
    assign win_write = gnt_oh[PORT_D] ? d_write : i_write;
    assign win_addr  = gnt_oh[PORT_D] ? d_addr  : i_addr;
    assign win_wdata = gnt_oh[PORT_D] ? d_wdata : i_wdata;

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state     <= IDLE;
            grant     <= PORT_D;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        grant     <= gnt_idx;
                        mem_addr  <= win_addr;
                        mem_wdata <= win_wdata;
                        mem_write <= win_write;
                        mem_read  <= win_read & ~win_write;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= GAP;
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Ready is passed straight through, but only to the port holding the grant.
    assign done      = (state == BUSY) && mem_ready;
    assign i_ready   = done && (grant == PORT_I);
    assign d_ready   = done && (grant == PORT_D);
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: round-robin instance plus a fixed-priority instance.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW   = 28;
  localparam int DW   = 128;
  localparam int SB_W = 1 + 2 + AW + 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic proc_reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- round-robin DUT ----------------
  logic          i_read, i_write, d_read, d_write, mem_ready;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_wdata, d_wdata, mem_rdata;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic          i_ready, d_ready, mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [1:0]    dbg_state;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b1)) dut (
    .clk(clk), .proc_reset_n(proc_reset_n),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- fixed-priority DUT ----------------
  logic          f_i_read, f_d_read, f_mem_ready;
  logic [AW-1:0] f_i_addr, f_d_addr, f_mem_addr;
  logic [DW-1:0] f_i_rdata, f_d_rdata, f_mem_wdata;
  logic          f_i_ready, f_d_ready, f_mem_read, f_mem_write;
  logic [1:0]    f_dbg_state;
  logic          f_zero = 1'b0;
  logic [DW-1:0] f_wzero = '0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .proc_reset_n(proc_reset_n),
    .i_read(f_i_read), .i_write(f_zero), .i_addr(f_i_addr), .i_wdata(f_wzero),
    .i_rdata(f_i_rdata), .i_ready(f_i_ready),
    .d_read(f_d_read), .d_write(f_zero), .d_addr(f_d_addr), .d_wdata(f_wzero),
    .d_rdata(f_d_rdata), .d_ready(f_d_ready),
    .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_addr(f_mem_addr),
    .mem_wdata(f_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(f_mem_ready),
    .dbg_state(f_dbg_state)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  // Entry: {port, write, read, addr, wdata[15:0]} for each expected memory request.
  logic [SB_W-1:0] exp_q[$];
  logic            cur_port = PORT_D;
  logic [1:0]      prev_state = 2'd0;

  task automatic push_exp(input logic port, input logic w, input logic r,
                          input logic [AW-1:0] a, input logic [15:0] wd);
    exp_q.push_back({port, w, r, a, wd});
  endtask

  always @(negedge clk) begin
    logic [SB_W-1:0] e;
    if (prev_state == IDLE && dbg_state == BUSY) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        cur_port = e[SB_W-1];
        check("sb_txn", {mem_write, mem_read, mem_addr, mem_wdata[15:0]}, e[SB_W-2:0]);
      end
    end
    prev_state = dbg_state;
  end

  // ---------------- driver tasks ----------------
  task automatic serve(input int lat, input logic [DW-1:0] rd);
    int n = 0;
    while (dbg_state != BUSY && n < 20) begin
      tick();
      n++;
    end
    if (dbg_state != BUSY) check("busy_timeout", dbg_state, BUSY);
    repeat (lat) tick();
    mem_rdata = rd;
    mem_ready = 1'b1;
    #1;
    check("i_ready", i_ready, cur_port == PORT_I);
    check("d_ready", d_ready, cur_port == PORT_D);
    check("rdata", (cur_port == PORT_D) ? d_rdata : i_rdata, rd);
    tick();
    mem_ready = 1'b0;
    check("gap_state", dbg_state, GAP);
    check("gap_mem_rw", {mem_read, mem_write}, 2'b00);
  endtask

  task automatic do_reset();
    proc_reset_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("rst_state", dbg_state, IDLE);
    check("rst_mem_rw", {mem_read, mem_write}, 2'b00);
    check("rst_ready", {i_ready, d_ready}, 2'b00);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    mem_ready = 1'b0;
    tick();
    tick();
    proc_reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
    d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
    f_i_read = 0; f_d_read = 0; f_i_addr = '0; f_d_addr = '0; f_mem_ready = 0;
    tick();
    do_reset();

    // Single D read: request in cycle 0, mem_read from cycle 1, ready at cycle 4.
    d_read = 1; d_addr = 28'h0000123;
    push_exp(PORT_D, 1'b0, 1'b1, 28'h0000123, 16'h0);
    #1;
    check("t1_lat0", mem_read, 1'b0);
    tick();
    check("t1_mem_read", mem_read, 1'b1);
    check("t1_mem_addr", mem_addr, 28'h0000123);
    serve(3, {16{8'hA5}});
    d_read = 0;
    tick();

    // Write-back, then allocate read raised straight after the ready.
    d_write = 1; d_addr = 28'h10; d_wdata = 128'h1234;
    push_exp(PORT_D, 1'b1, 1'b0, 28'h10, 16'h1234);
    tick();
    check("t2_mem_write", mem_write, 1'b1);
    check("t2_mem_read", mem_read, 1'b0);
    check("t2_mem_wdata", mem_wdata, 128'h1234);
    serve(2, 128'h0);
    d_write = 0; d_read = 1; d_addr = 28'h20;
    push_exp(PORT_D, 1'b0, 1'b1, 28'h20, 16'h1234);
    tick();
    check("t2_idle_gap", mem_read, 1'b0);
    tick();
    check("t2_alloc_read", mem_read, 1'b1);
    check("t2_alloc_addr", mem_addr, 28'h20);
    serve(1, 128'hBEEF);
    d_read = 0;

    // Both ports held from reset: grants alternate D, I, D, I.
    do_reset();
    i_read = 1; i_addr = 28'h100; d_read = 1; d_addr = 28'h200;
    push_exp(PORT_D, 1'b0, 1'b1, 28'h200, 16'h1234);
    push_exp(PORT_I, 1'b0, 1'b1, 28'h100, 16'h0);
    push_exp(PORT_D, 1'b0, 1'b1, 28'h200, 16'h1234);
    push_exp(PORT_I, 1'b0, 1'b1, 28'h100, 16'h0);
    for (int k = 0; k < 4; k++) serve($urandom_range(1, 3), DW'($urandom));
    i_read = 0; d_read = 0;
    tick();

    // Inputs change during BUSY; the grant and address stay put.
    d_read = 1; d_addr = 28'h300;
    push_exp(PORT_D, 1'b0, 1'b1, 28'h300, 16'h1234);
    tick();
    d_addr = 28'h301; i_read = 1; i_addr = 28'h400;
    push_exp(PORT_I, 1'b0, 1'b1, 28'h400, 16'h0);
    tick();
    check("t4_addr_held", mem_addr, 28'h300);
    serve(1, 128'h77);
    d_read = 0;
    serve(1, 128'h88);
    i_read = 0;
    tick();

    // Reset while BUSY: outputs drop at once, no ready.
    d_read = 1; d_addr = 28'h500;
    push_exp(PORT_D, 1'b0, 1'b1, 28'h500, 16'h1234);
    tick();
    tick();
    check("t5_busy", mem_read, 1'b1);
    #2;
    proc_reset_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("t5_async_rw", {mem_read, mem_write}, 2'b00);
    check("t5_async_ready", {i_ready, d_ready}, 2'b00);
    mem_ready = 1'b0;
    tick();
    proc_reset_n = 1'b1;
    i_read = 1; i_addr = 28'h501; d_addr = 28'h502;
    check("t5_idle", dbg_state, IDLE);
    push_exp(PORT_D, 1'b0, 1'b1, 28'h502, 16'h1234);
    serve(1, 128'h99);
    i_read = 0; d_read = 0;
    tick();

    // Stray mem_ready in IDLE and in GAP.
    mem_ready = 1'b1;
    #1;
    check("t6_idle_ready", {i_ready, d_ready}, 2'b00);
    tick();
    mem_ready = 1'b0;
    check("t6_idle_state", dbg_state, IDLE);
    check("t6_idle_rw", {mem_read, mem_write}, 2'b00);
    d_read = 1; d_addr = 28'h600;
    push_exp(PORT_D, 1'b0, 1'b1, 28'h600, 16'h1234);
    serve(1, 128'h66);
    d_read = 0;
    mem_ready = 1'b1;
    #1;
    check("t6_gap_ready", {i_ready, d_ready}, 2'b00);
    tick();
    mem_ready = 1'b0;
    check("t6_gap_state", dbg_state, IDLE);

    // Fixed priority: D always wins while held, I is never served.
    f_i_read = 1; f_i_addr = 28'h111; f_d_read = 1; f_d_addr = 28'h222;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (f_dbg_state != BUSY && n < 20) begin
        tick();
        n++;
      end
      check("fp_busy", f_dbg_state, BUSY);
      check("fp_addr", f_mem_addr, 28'h222);
      f_mem_ready = 1'b1;
      #1;
      check("fp_d_ready", f_d_ready, 1'b1);
      check("fp_i_ready", f_i_ready, 1'b0);
      tick();
      f_mem_ready = 1'b0;
    end
    f_i_read = 0; f_d_read = 0;
    tick();
    tick();

    check("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
